// File: rtl/tpic2mem.sv
// Reads the TPIC relay chain back through sin while recirculating it on sout; done pulses 2*HALF*WIDTH+1 clks after start.
// No backpressure: start is honoured only when idle; data/mismatch update only at readback completion.
module tpic2mem #(
   parameter int WIDTH = 300,
   parameter int HALF  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sin,
   input  logic [WIDTH-1:0] expected,
   output logic             sclk,
   output logic             sout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data,
   output logic             mismatch
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;

   typedef enum logic [1:0] {IDLE, LOW, HIGH, FINISH} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [HW-1:0]    half_cnt_q, half_cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             sclk_q, sclk_d;
   logic             sout_q, sout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             mismatch_q, mismatch_d;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      half_cnt_d = half_cnt_q;
      sr_d       = sr_q;
      data_d     = data_q;
      sclk_d     = sclk_q;
      sout_d     = sout_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      mismatch_d = mismatch_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = LOW;
               busy_d     = 1'b1;
               bit_cnt_d  = '0;
               half_cnt_d = '0;
               sclk_d     = 1'b0;
            end
         end
         LOW: begin
            // Sample once per bit, well after the previous sclk rise moved the chain.
            if (half_cnt_q == '0) begin
               sr_d   = WIDTH'({sr_q, sin});
               sout_d = sin;
            end
            if (half_cnt_q == HW'(HALF - 1)) begin
               half_cnt_d = '0;
               state_d    = HIGH;
               sclk_d     = 1'b1;
            end else begin
               half_cnt_d = half_cnt_q + HW'(1);
            end
         end
         HIGH: begin
            if (half_cnt_q == HW'(HALF - 1)) begin
               half_cnt_d = '0;
               sclk_d     = 1'b0;
               if (bit_cnt_q == CW'(WIDTH - 1)) begin
                  state_d = FINISH;
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
                  state_d   = LOW;
               end
            end else begin
               half_cnt_d = half_cnt_q + HW'(1);
            end
         end
         FINISH: begin
            data_d     = sr_q;
            mismatch_d = (sr_q != expected);
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         half_cnt_q <= '0;
         sr_q       <= '0;
         data_q     <= '0;
         sclk_q     <= 1'b0;
         sout_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         half_cnt_q <= half_cnt_d;
         sr_q       <= sr_d;
         data_q     <= data_d;
         sclk_q     <= sclk_d;
         sout_q     <= sout_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign sclk     = sclk_q;
   assign sout     = sout_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign data     = data_q;
   assign mismatch = mismatch_q;

endmodule

// File: tb/tb_tpic2mem.sv
// Bench for tpic2mem: a recirculating TPIC chain model feeds sin, readbacks are scored against the chain image.
module tb_tpic2mem;
   localparam int W = 16;
   localparam int H = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         sin;
   logic [W-1:0] expected = '0;
   logic         sclk, sout, busy, done, mismatch;
   logic [W-1:0] data;

   logic         t_start = 1'b0;
   logic         t_sin = 1'b1;
   logic [0:0]   t_exp = 1'b1;
   logic         t_sclk, t_sout, t_busy, t_done, t_mismatch;
   logic [0:0]   t_data;

   tpic2mem #(.WIDTH(W), .HALF(H)) dut (
      .clk(clk), .reset(reset), .start(start), .sin(sin), .expected(expected),
      .sclk(sclk), .sout(sout), .busy(busy), .done(done), .data(data), .mismatch(mismatch));

   tpic2mem #(.WIDTH(1), .HALF(1)) dut_tiny (
      .clk(clk), .reset(reset), .start(t_start), .sin(t_sin), .expected(t_exp),
      .sclk(t_sclk), .sout(t_sout), .busy(t_busy), .done(t_done), .data(t_data), .mismatch(t_mismatch));

   always #10 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Chain model: on every sclk rise the chain shifts toward sin and takes sout in at the far end.
   logic [W-1:0] chain = '0;
   int           rises = 0;
   int           t_rises = 0;
   logic         sout_log[$];
   assign sin = chain[W-1];

   always @(posedge sclk) begin
      rises++;
      sout_log.push_back(sout);
      chain = {chain[W-2:0], sout};
   end

   always @(posedge t_sclk) t_rises++;

   int done_pulses = 0;
   always @(negedge clk) if (done === 1'b1) done_pulses++;

   logic [W-1:0] m_data = '0;
   logic         m_mm = 1'b0;

   task automatic test_reset();
      int k;
      repeat (3) @(negedge clk);
      n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got=%b want=0", sclk); end
      n_tests++; if (sout !== 1'b0) begin n_fail++; $display("FAIL reset_sout got=%b want=0", sout); end
      n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
      n_tests++; if (data !== '0 || mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_data got=%h/%b want=0000/0", data, mismatch); end
      chain = 16'h3C5A; expected = 16'h3C5A;
      @(negedge clk); reset = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_start busy got=%b want=1", busy); end
      k = 0;
      while (done !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      m_data = 16'h3C5A; m_mm = 1'b0;
      n_tests++; if (k != 2*H*W+1 || data !== m_data) begin n_fail++; $display("FAIL first_readback cyc=%0d data=%h want cyc=%0d data=%h", k, data, 2*H*W+1, m_data); end
      repeat (2) @(negedge clk);
   endtask

   task automatic run_readback(input logic [W-1:0] img, input logic [W-1:0] exp_final, input bit repulse, input string tag);
      int k, dp0, unstable;
      logic [W-1:0] got;
      chain = img; rises = 0; sout_log.delete(); unstable = 0; dp0 = done_pulses; got = '0;
      @(negedge clk); start = 1'b1; expected = W'($urandom);
      @(negedge clk); start = 1'b0; k = 0;
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy got=%b want=1", tag, busy); end
      while (done !== 1'b1 && k < 200) begin
         start = repulse && (k == 10 || k == 40);
         if (k < 60) expected = W'($urandom); else expected = exp_final;
         @(negedge clk); k++;
         if (done !== 1'b1 && (data !== m_data || mismatch !== m_mm)) unstable++;
      end
      start = 1'b0;
      n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL %s outputs_moved_while_busy got=%0d want=0", tag, unstable); end
      m_data = img; m_mm = (img != exp_final);
      n_tests++; if (k != 2*H*W+1) begin n_fail++; $display("FAIL %s latency got=%0d want=%0d", tag, k, 2*H*W+1); end
      n_tests++; if (data !== m_data) begin n_fail++; $display("FAIL %s data got=%h want=%h", tag, data, m_data); end
      n_tests++; if (mismatch !== m_mm || busy !== 1'b0) begin n_fail++; $display("FAIL %s mismatch/busy got=%b/%b want=%b/0", tag, mismatch, busy, m_mm); end
      n_tests++; if (rises != W) begin n_fail++; $display("FAIL %s sclk_rises got=%0d want=%0d", tag, rises, W); end
      foreach (sout_log[i]) got = {got[W-2:0], sout_log[i]};
      n_tests++; if (got !== img) begin n_fail++; $display("FAIL %s sout_seq got=%h want=%h", tag, got, img); end
      n_tests++; if (chain !== img) begin n_fail++; $display("FAIL %s chain_preserved got=%h want=%h", tag, chain, img); end
      repeat (3) @(negedge clk);
      n_tests++; if (done_pulses - dp0 != 1) begin n_fail++; $display("FAIL %s done_pulses got=%0d want=1", tag, done_pulses - dp0); end
      n_tests++; if (mismatch !== m_mm || data !== m_data) begin n_fail++; $display("FAIL %s hold got=%h/%b want=%h/%b", tag, data, mismatch, m_data, m_mm); end
   endtask

   task automatic test_random(input int n);
      logic [W-1:0] img, ex;
      for (int i = 0; i < n; i++) begin
         img = W'($urandom);
         ex  = ($urandom_range(0, 1) == 1) ? img : img ^ (W'(1) << $urandom_range(0, W-1));
         run_readback(img, ex, ($urandom_range(0, 1) == 1), "random");
      end
   endtask

   task automatic test_reset_mid();
      int dp0;
      chain = 16'hA5C3; dp0 = done_pulses; expected = 16'hA5C3;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (30) @(negedge clk);
      reset = 1'b0;
      #1;
      n_tests++; if (sclk !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid sclk/busy got=%b/%b want=0/0", sclk, busy); end
      n_tests++; if (data !== '0 || mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_mid data got=%h/%b want=0000/0", data, mismatch); end
      m_data = '0; m_mm = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (80) @(negedge clk);
      n_tests++; if (done_pulses != dp0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid no_done got=%0d busy=%b want=0 busy=0", done_pulses - dp0, busy); end
      run_readback(16'hA5C3, 16'hA5C3, 1'b0, "after_reset");
   endtask

   task automatic test_back_to_back(input logic [W-1:0] img);
      int t[3];
      int nd, k, lowrun, minrun, bad_data;
      bit pending;
      chain = img; expected = img; nd = 0; k = 0; lowrun = 0; minrun = 1000; bad_data = 0; pending = 0;
      @(negedge clk); start = 1'b1;
      while (nd < 3 && k < 400) begin
         @(negedge clk); k++;
         if (sclk === 1'b0) lowrun++;
         else begin
            if (pending && lowrun < minrun) minrun = lowrun;
            pending = 0; lowrun = 0;
         end
         if (done === 1'b1) begin
            t[nd] = k; nd++; pending = 1;
            if (data !== img || mismatch !== 1'b0) bad_data++;
         end
      end
      start = 1'b0;
      m_data = img; m_mm = 1'b0;
      n_tests++; if (nd != 3) begin n_fail++; $display("FAIL b2b done_count got=%0d want=3", nd); end
      else begin
         n_tests++; if (t[1] - t[0] != 66 || t[2] - t[1] != 66) begin n_fail++; $display("FAIL b2b spacing got=%0d,%0d want=66,66", t[1]-t[0], t[2]-t[1]); end
      end
      n_tests++; if (minrun < 2) begin n_fail++; $display("FAIL b2b sclk_low_gap got=%0d want>=2", minrun); end
      n_tests++; if (bad_data != 0) begin n_fail++; $display("FAIL b2b data got=%0d bad want=0", bad_data); end
      repeat (80) @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b idle_after got=%b want=0", busy); end
   endtask

   task automatic test_tiny();
      int k;
      t_rises = 0;
      @(negedge clk); t_start = 1'b1;
      @(negedge clk); t_start = 1'b0; k = 0;
      while (t_done !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      n_tests++; if (k != 3) begin n_fail++; $display("FAIL tiny_latency got=%0d want=3", k); end
      n_tests++; if (t_rises != 1) begin n_fail++; $display("FAIL tiny_rises got=%0d want=1", t_rises); end
      n_tests++; if (t_data !== 1'b1 || t_mismatch !== 1'b0) begin n_fail++; $display("FAIL tiny_data got=%b/%b want=1/0", t_data, t_mismatch); end
   endtask

   initial begin
      test_reset();
      run_readback(16'hA5C3, 16'hA5C3, 1'b0, "match");
      run_readback(16'hA5C3, 16'hA5C2, 1'b0, "mismatch");
      run_readback(16'hA5C3, 16'hA5C3, 1'b1, "repulse");
      test_random(5);
      test_reset_mid();
      test_back_to_back(16'hA5C3);
      test_tiny();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
